// File: rtl/seq_pattern_generator_if.sv
// Control and serial-output bundle for seq_pattern_generator.
// The bench drives through the master modport; the generator sits on the slave modport.
interface seq_pattern_generator_if #(
    parameter int unsigned MAX_LEN = 8
);
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] pattern;
    logic [3:0]         len;
    logic [3:0]         rep;
    logic [2:0]         gap;

    logic               dout;
    logic               valid;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, pattern, len, rep, gap,
        input  dout, valid, busy, done, err
    );

    modport slave (
        input  start, abort, pattern, len, rep, gap,
        output dout, valid, busy, done, err
    );
endinterface

// File: rtl/seq_pattern_generator.sv
// Serial pattern generator: sends a captured pattern MSB-first, repeated rep times with
// gap idle cycles between repetitions. Every output comes straight from a flop.
module seq_pattern_generator #(
    parameter int unsigned MAX_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_pattern_generator_if.slave bus
);

    localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap,
        StDone
    } state_e;

    state_e             state_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [IdxW-1:0]    top_idx_q;
    logic [IdxW-1:0]    bit_idx_q;
    logic [3:0]         rep_left_q;
    logic [2:0]         gap_q;
    logic [2:0]         gap_cnt_q;

    logic dout_q;
    logic valid_q;
    logic busy_q;
    logic done_q;
    logic err_q;

    // Lengths beyond MAX_LEN are clamped; start_idx is the first (MSB) bit to send.
    logic [3:0]      eff_len;
    logic [IdxW-1:0] start_idx;

    assign eff_len   = (32'(bus.len) > MAX_LEN) ? 4'(MAX_LEN) : bus.len;
    assign start_idx = IdxW'(eff_len - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pattern_q  <= '0;
            top_idx_q  <= '0;
            bit_idx_q  <= '0;
            rep_left_q <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            dout_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.len == 4'd0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= StShift;
                            pattern_q  <= bus.pattern;
                            top_idx_q  <= start_idx;
                            bit_idx_q  <= start_idx;
                            rep_left_q <= (bus.rep == 4'd0) ? 4'd1 : bus.rep;
                            gap_q      <= bus.gap;
                            gap_cnt_q  <= '0;
                            dout_q     <= bus.pattern[start_idx];
                            valid_q    <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end

                StShift: begin
                    if (bus.abort) begin
                        state_q    <= StIdle;
                        bit_idx_q  <= '0;
                        rep_left_q <= '0;
                        dout_q     <= 1'b0;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (bit_idx_q != '0) begin
                        bit_idx_q <= bit_idx_q - 1'b1;
                        dout_q    <= pattern_q[bit_idx_q - 1'b1];
                    end else if (rep_left_q > 4'd1) begin
                        // rep_left_q counts the repetition now finishing, so >1 means more follow.
                        rep_left_q <= rep_left_q - 4'd1;
                        if (gap_q != 3'd0) begin
                            state_q   <= StGap;
                            gap_cnt_q <= gap_q;
                            dout_q    <= 1'b0;
                            valid_q   <= 1'b0;
                        end else begin
                            bit_idx_q <= top_idx_q;
                            dout_q    <= pattern_q[top_idx_q];
                        end
                    end else begin
                        state_q    <= StDone;
                        rep_left_q <= '0;
                        dout_q     <= 1'b0;
                        valid_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end

                StGap: begin
                    if (bus.abort) begin
                        state_q    <= StIdle;
                        gap_cnt_q  <= '0;
                        rep_left_q <= '0;
                        busy_q     <= 1'b0;
                    end else if (gap_cnt_q == 3'd1) begin
                        state_q   <= StShift;
                        gap_cnt_q <= '0;
                        bit_idx_q <= top_idx_q;
                        dout_q    <= pattern_q[top_idx_q];
                        valid_q   <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 3'd1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// Bench for seq_pattern_generator: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a per-transaction queue model.
module tb_seq_pattern_generator;

    localparam int unsigned MaxLen = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_pattern_generator_if #(.MAX_LEN(MaxLen)) bus ();

    seq_pattern_generator #(.MAX_LEN(MaxLen)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic busy;
        logic valid;
        logic dout;
        logic done;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur = '0;

    int checks = 0;
    int errors = 0;

    // Expand one accepted start into the full per-cycle output sequence.
    function automatic void build(input logic [MaxLen-1:0] pat, input int l, input int r,
                                  input int g);
        int eff;
        int reps;
        eff  = (l > int'(MaxLen)) ? int'(MaxLen) : l;
        reps = (r == 0) ? 1 : r;
        for (int i = 0; i < reps; i++) begin
            for (int k = 0; k < eff; k++) exp_q.push_back(exp_t'({2'b11, pat[eff-1-k], 2'b00}));
            if (i < reps - 1) begin
                for (int j = 0; j < g; j++) exp_q.push_back(exp_t'(5'b10000));
            end
        end
        exp_q.push_back(exp_t'(5'b00010));
    endfunction

    // cur holds the expected outputs for the cycle following each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur <= '0;
        end else if (bus.abort && cur.busy) begin
            exp_q.delete();
            cur <= '0;
        end else if (exp_q.size() > 0) begin
            cur <= exp_q.pop_front();
        end else if (cur.done) begin
            cur <= '0;
        end else if (bus.start && bus.len == 4'd0) begin
            cur <= exp_t'(5'b00001);
        end else if (bus.start) begin
            build(bus.pattern, int'(bus.len), int'(bus.rep), int'(bus.gap));
            cur <= exp_q.pop_front();
        end else begin
            cur <= '0;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({bus.busy, bus.valid, bus.dout, bus.done, bus.err} !== cur) begin
            errors++;
            $display("FAIL model_cycle t=%0t busy/valid/dout/done/err got %b expected %b",
                     $time, {bus.busy, bus.valid, bus.dout, bus.done, bus.err}, cur);
        end
    end

    // Non-overlapping 1011 detector fed from the valid serial stream.
    logic [3:0] det_sh = '0;
    int         det_n = 0;
    int         det_hits = 0;

    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            det_sh = {det_sh[2:0], bus.dout};
            det_n++;
            if (det_n >= 4 && det_sh == 4'b1011) begin
                det_hits++;
                det_n = 0;
            end
        end
    end

    logic [31:0] r_dout, r_valid, r_busy, r_done, r_err;

    task automatic clear_rec();
        r_dout  = '0;
        r_valid = '0;
        r_busy  = '0;
        r_done  = '0;
        r_err   = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        r_dout  = {r_dout[30:0], bus.dout};
        r_valid = {r_valid[30:0], bus.valid};
        r_busy  = {r_busy[30:0], bus.busy};
        r_done  = {r_done[30:0], bus.done};
        r_err   = {r_err[30:0], bus.err};
    endtask

    task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, want);
        end
    endtask

    task automatic launch(input logic [MaxLen-1:0] pat, input logic [3:0] l, input logic [3:0] r,
                          input logic [2:0] g);
        bus.pattern = pat;
        bus.len     = l;
        bus.rep     = r;
        bus.gap     = g;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.rep     = '0;
        bus.gap     = '0;
        clear_rec();
        repeat (3) tick();
        check_vec("reset_outputs",
                  {27'd0, bus.busy, bus.valid, bus.dout, bus.done, bus.err}, 32'd0);
        rst = 1'b0;

        // Single repetition, started on the first edge after reset release.
        clear_rec();
        launch(8'h0B, 4'd4, 4'd1, 3'd0);
        repeat (5) tick();
        check_vec("rep1_dout", r_dout, 32'b101100);
        check_vec("rep1_valid", r_valid, 32'b111100);
        check_vec("rep1_busy", r_busy, 32'b111100);
        check_vec("rep1_done", r_done, 32'b000010);

        clear_rec();
        launch(8'h0B, 4'd4, 4'd2, 3'd2);
        repeat (11) tick();
        check_vec("gap2_dout", r_dout, 32'b101100101100);
        check_vec("gap2_valid", r_valid, 32'b111100111100);
        check_vec("gap2_busy", r_busy, 32'b111111111100);
        check_vec("gap2_done", r_done, 32'b000000000010);

        clear_rec();
        launch(8'h0B, 4'd4, 4'd2, 3'd0);
        repeat (9) tick();
        check_vec("gap0_dout", r_dout, 32'b1011101100);
        check_vec("gap0_valid", r_valid, 32'b1111111100);
        check_vec("gap0_done", r_done, 32'b0000000010);

        clear_rec();
        launch(8'h0B, 4'd0, 4'd1, 3'd0);
        repeat (2) tick();
        check_vec("len0_err", r_err, 32'b100);
        check_vec("len0_quiet", r_busy | r_valid | r_done, 32'd0);

        clear_rec();
        launch(8'hA5, 4'd9, 4'd1, 3'd0);
        repeat (9) tick();
        check_vec("clamp_dout", r_dout, 32'b1010010100);
        check_vec("clamp_valid", r_valid, 32'b1111111100);

        // Start held into the transfer with new inputs, then abort during the third bit.
        clear_rec();
        launch(8'h0B, 4'd4, 4'd1, 3'd0);
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.len     = 4'd2;
        tick();
        bus.start = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        check_vec("abort_dout", r_dout, 32'b10100);
        check_vec("abort_valid", r_valid, 32'b11100);
        check_vec("abort_busy", r_busy, 32'b11100);
        check_vec("abort_done_err", r_done | r_err, 32'd0);

        // Reset during the gap, then a fresh transfer.
        clear_rec();
        launch(8'h0B, 4'd4, 4'd2, 3'd4);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        launch(8'h0B, 4'd4, 4'd1, 3'd0);
        repeat (5) tick();
        check_vec("rstgap_dout", r_dout, 32'b1011000101100);
        check_vec("rstgap_valid", r_valid, 32'b1111000111100);
        check_vec("rstgap_busy", r_busy, 32'b1111100111100);
        check_vec("rstgap_done", r_done, 32'b0000000000010);

        det_sh   = '0;
        det_n    = 0;
        det_hits = 0;
        launch(8'h0B, 4'd4, 4'd3, 3'd0);
        repeat (13) tick();
        checks++;
        if (det_hits != 3) begin
            errors++;
            $display("FAIL loopback_detections got %0d expected 3", det_hits);
        end

        for (int i = 0; i < 4000; i++) begin
            bus.start   = ($urandom_range(0, 3) == 0);
            bus.abort   = ($urandom_range(0, 47) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            bus.pattern = MaxLen'($urandom);
            bus.len     = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            bus.rep     = 4'($urandom_range(0, 15));
            bus.gap     = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_generator.md
SEQ_PATTERN_GENERATOR -- requirements
Module: seq_pattern_generator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to begin a transmission; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminate an active transmission.
REQ-006 SHALL have port pattern, input, MAX_LEN, bits to send, MSB-first from bit len-1.
REQ-007 SHALL have port len, input, 4, number of pattern bits per repetition.
REQ-008 SHALL have port rep, input, 4, repetition count.
REQ-009 SHALL have port gap, input, 3, idle cycles inserted between repetitions.
REQ-010 SHALL have port dout, output, 1, registered serial bit stream, detector-compatible.
REQ-011 SHALL have port valid, output, 1, dout carries a pattern bit this cycle.
REQ-012 SHALL have port busy, output, 1, transmission in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-014 SHALL have port err, output, 1, one-cycle pulse on a rejected start.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT, GAP and DONE.
REQ-016 IDLE: start=1 with 1<=len SHALL capture pattern, effective len, rep and gap at that edge and enter SHIFT; the first bit is visible on dout in the cycle after the edge.
REQ-017 Effective len SHALL be len when len<=MAX_LEN and MAX_LEN when len>MAX_LEN (clamp).
REQ-018 rep=0 SHALL be treated as 1.
REQ-019 IDLE with start=1 and len=0 SHALL stay in IDLE and pulse err for 1 cycle; busy, valid and done remain 0.
REQ-020 SHIFT: each cycle SHALL drive dout = captured bit (effective len-1-k) for k=0..len-1, with valid=1 and busy=1.
REQ-021 At the end of the last bit of a repetition: if repetitions remain and gap>0, the FSM SHALL enter GAP.
REQ-022 At the end of the last bit of a repetition: if repetitions remain and gap=0, the FSM SHALL restart SHIFT with no idle cycle.
REQ-023 At the end of the last bit of the final repetition, the FSM SHALL enter DONE.
REQ-024 GAP SHALL last exactly gap cycles with dout=0, valid=0 and busy=1, then return to SHIFT at bit len-1.
REQ-025 DONE SHALL last 1 cycle with done=1, busy=0, valid=0 and dout=0, then go to IDLE.
REQ-026 A start arriving during DONE SHALL be ignored; start SHALL be accepted again in the following IDLE cycle.
REQ-027 start asserted while busy=1 SHALL be ignored, and the captured configuration SHALL be unaffected by input changes.
REQ-028 abort=1 in SHIFT or GAP SHALL force IDLE at the next edge with dout=0, valid=0, busy=0 and no done pulse.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 When start and abort are both 1 in IDLE, start SHALL take priority.
REQ-031 The bit index counter SHALL be at least clog2(MAX_LEN) bits wide, and the repetition and gap counters 4 and 3 bits wide; counters SHALL never wrap.
REQ-032 dout SHALL be 0 whenever valid=0.
REQ-033 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-034 rst=1 at a rising edge SHALL force IDLE.
REQ-035 rst=1 at a rising edge SHALL clear all counters and capture registers.
REQ-036 rst=1 at a rising edge SHALL drive dout=0, valid=0, busy=0, done=0 and err=0 from the next cycle, including mid-SHIFT or mid-GAP.
REQ-037 rst SHALL take priority over start and abort.
REQ-038 The first start SHALL be accepted in the cycle after rst deasserts.

Verification
REQ-039 pattern=8'h0B, len=4, rep=1, gap=0 -> dout 1,0,1,1 with valid=1 for 4 cycles, then done=1 for 1 cycle, then IDLE.
REQ-040 pattern=8'h0B, len=4, rep=2, gap=2 -> dout 1,0,1,1,0,0,1,0,1,1 with valid 1111 00 1111, busy high for 10 cycles, then done pulse.
REQ-041 pattern=8'h0B, len=4, rep=2, gap=0 -> 8 contiguous valid bits 10111011, then done pulse.
REQ-042 start with len=0 -> err=1 for 1 cycle with busy/valid/done=0; start with len=9, pattern=8'hA5 -> 8 bits 10100101.
REQ-043 start pulsed during bit 2 of a transmission -> ignored with output unchanged; abort during the bit-3 cycle -> next cycle busy=0, valid=0, dout=0 and no done.
REQ-044 rst asserted mid-GAP -> next cycle all outputs 0 and state IDLE; a new start one cycle after rst deasserts transmits normally.
REQ-045 Loopback of dout into the team's non-overlapping detector with pattern equal to the detector sequence, rep=3, gap=0 -> exactly 3 detections.
